// File: rtl/sobel_window_gen_pkg.sv
// Shared constants for the 3x3 Sobel window generator: window element indices,
// pipeline latency and a counter-width helper.
package sobel_window_gen_pkg;

   localparam int K_TL = 0;
   localparam int K_TC = 1;
   localparam int K_TR = 2;
   localparam int K_ML = 3;
   localparam int K_MC = 4;
   localparam int K_MR = 5;
   localparam int K_BL = 6;
   localparam int K_BC = 7;
   localparam int K_BR = 8;

   localparam int WIN_LATENCY = 2;

   // Width of a counter or address that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// One-line pixel memory: simple dual-port, synchronous read, read-before-write
// when both ports hit the same address on the same edge.
module sobel_window_gen_line_buffer
   import sobel_window_gen_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int DW    = 12,
   parameter int AW    = cnt_width(DEPTH)
) (
   input  logic          i_clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // Both ports live in one block so a same-address read returns the pre-write contents.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting window register,
// emitting only windows that lie fully inside the image.
module sobel_window_gen
   import sobel_window_gen_pkg::*;
#(
   parameter int DW    = 12,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   input  logic          i_sof,
   output logic [9*DW-1:0] o_data,
   output logic          o_valid,
   output logic          o_sof
);

   localparam int XW = cnt_width(IMG_W);
   localparam int YW = cnt_width(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic [XW-1:0] x, cur_x, s1_x, s2_x;
   logic [YW-1:0] y, cur_y;
   logic          s1_valid, s1_emit, s1_first;
   logic          s2_valid, s2_emit, s2_first;
   logic [DW-1:0] s1_pix, s2_pix, lb0_q, lb1_q;

   // A start-of-frame pixel is pinned to (0,0) whatever the counters say.
   always_comb begin
      cur_x = i_sof ? '0 : x;
      cur_y = i_sof ? '0 : y;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         x <= '0;
         y <= '0;
      end else if (i_valid) begin
         if (cur_x == X_LAST) begin
            x <= '0;
            y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
         end else begin
            x <= cur_x + 1'b1;
            y <= cur_y;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_pix   <= i_data;
            s1_x     <= cur_x;
            s1_emit  <= (cur_x >= XW'(2)) && (cur_y >= YW'(2));
            s1_first <= (cur_x == XW'(2)) && (cur_y == YW'(2));
         end
      end
   end

   // LB1 takes the old LB0 word one cycle late, once LB0's read has returned it.
   sobel_window_gen_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(XW)) u_lb0 (
      .i_clk   (i_clk),
      .wr_en   (s1_valid),
      .wr_addr (s1_x),
      .wr_data (s1_pix),
      .rd_en   (s1_valid),
      .rd_addr (s1_x),
      .rd_data (lb0_q)
   );

   sobel_window_gen_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(XW)) u_lb1 (
      .i_clk   (i_clk),
      .wr_en   (s2_valid),
      .wr_addr (s2_x),
      .wr_data (lb0_q),
      .rd_en   (s1_valid),
      .rd_addr (s1_x),
      .rd_data (lb1_q)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_pix   <= s1_pix;
            s2_x     <= s1_x;
            s2_emit  <= s1_emit;
            s2_first <= s1_first;
         end
      end
   end

   // Window shifts left one column per accepted pixel; it holds through input gaps.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_data  <= '0;
         o_valid <= 1'b0;
         o_sof   <= 1'b0;
      end else begin
         o_valid <= s2_valid && s2_emit;
         o_sof   <= s2_valid && s2_first;
         if (s2_valid) begin
            o_data[K_TL*DW +: DW] <= o_data[K_TC*DW +: DW];
            o_data[K_TC*DW +: DW] <= o_data[K_TR*DW +: DW];
            o_data[K_TR*DW +: DW] <= lb1_q;
            o_data[K_ML*DW +: DW] <= o_data[K_MC*DW +: DW];
            o_data[K_MC*DW +: DW] <= o_data[K_MR*DW +: DW];
            o_data[K_MR*DW +: DW] <= lb0_q;
            o_data[K_BL*DW +: DW] <= o_data[K_BC*DW +: DW];
            o_data[K_BC*DW +: DW] <= o_data[K_BR*DW +: DW];
            o_data[K_BR*DW +: DW] <= s2_pix;
         end
      end
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 5x4 image, using a frame-image
// reference model that builds each expected window straight from pixel coordinates.
module tb_sobel_window_gen;

   localparam int DW    = 12;
   localparam int IMG_W = 5;
   localparam int IMG_H = 4;
   localparam int WW    = 9 * DW;

   logic          i_clk   = 1'b0;
   logic          i_rstn  = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_sof   = 1'b0;
   logic [DW-1:0] i_data  = '0;
   logic [WW-1:0] o_data;
   logic          o_valid;
   logic          o_sof;

   typedef struct {
      logic [WW-1:0] data;
      logic          sof;
      int            cyc;
   } win_t;

   win_t          exp_q[$];
   win_t          obs_q[$];
   logic [DW-1:0] img [IMG_H][IMG_W];
   int            mx = 0, my = 0, cyc = 0, last_accept = 0;
   int            errors = 0, checks = 0;

   sobel_window_gen #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_sof   (i_sof),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_sof   (o_sof)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Every emitted window is recorded with the edge number that produced it.
   always @(negedge i_clk) begin
      if (o_valid === 1'b1) obs_q.push_back(win_t'{o_data, o_sof, cyc});
   end

   // Drives one cycle and, for an accepted pixel, places it in the model image;
   // a pixel at x>=2, y>=2 completes a window due two edges after acceptance.
   task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] d);
      win_t w;
      @(negedge i_clk);
      i_valid = v;
      i_sof   = s;
      i_data  = d;
      if (v) begin
         last_accept = cyc + 1;
         if (s) begin
            mx = 0;
            my = 0;
         end
         img[my][mx] = d;
         if (mx >= 2 && my >= 2) begin
            w.data = '0;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  w.data[(3*r + c)*DW +: DW] = img[my-2+r][mx-2+c];
            w.sof = (mx == 2 && my == 2);
            w.cyc = last_accept + 2;
            exp_q.push_back(w);
         end
         mx++;
         if (mx == IMG_W) begin
            mx = 0;
            my++;
            if (my == IMG_H) my = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, DW'($urandom));
   endtask

   task automatic send_frame(input int base, input bit with_sof, input bit gaps);
      for (int yy = 0; yy < IMG_H; yy++)
         for (int xx = 0; xx < IMG_W; xx++) begin
            if (gaps) idle($urandom_range(0, 2));
            applyStimulus(1'b1, with_sof && xx == 0 && yy == 0, DW'(base + 10*yy + xx));
         end
   endtask

   task automatic start_test();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_o_valid got=%b exp=0", o_valid);
      end
      checks++;
      if (o_sof !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_o_sof got=%b exp=0", o_sof);
      end
      checks++;
      if (o_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_o_data got=%h exp=0", o_data);
      end
      i_rstn = 1'b1;
      mx = 0;
      my = 0;
   endtask

   task automatic test_full_frame();
      int first_k[9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
      int last_k[9]  = '{12, 13, 14, 22, 23, 24, 32, 33, 34};
      start_test();
      send_frame(0, 1'b1, 1'b0);
      idle(4);
      checks++;
      if (obs_q.size() !== 6) begin
         errors++;
         $display("[TB] FAIL full_frame_count got=%0d exp=6", obs_q.size());
      end
      if (obs_q.size() == 6) begin
         checks++;
         if (obs_q[0].sof !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_frame_first_sof got=%b exp=1", obs_q[0].sof);
         end
         for (int k = 0; k < 9; k++) begin
            checks++;
            if (obs_q[0].data[k*DW +: DW] !== DW'(first_k[k])) begin
               errors++;
               $display("[TB] FAIL full_frame_first_k%0d got=%0d exp=%0d", k, obs_q[0].data[k*DW +: DW], first_k[k]);
            end
            checks++;
            if (obs_q[5].data[k*DW +: DW] !== DW'(last_k[k])) begin
               errors++;
               $display("[TB] FAIL full_frame_last_k%0d got=%0d exp=%0d", k, obs_q[5].data[k*DW +: DW], last_k[k]);
            end
         end
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].sof !== exp_q[i].sof || obs_q[i].cyc !== exp_q[i].cyc) begin
            errors++;
            $display("[TB] FAIL full_frame_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i, obs_q[i].data, obs_q[i].sof, obs_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].cyc);
         end
      end
   endtask

   task automatic test_latency();
      int t22 = 0;
      start_test();
      for (int i = 0; i < IMG_W*IMG_H; i++) begin
         applyStimulus(1'b1, i == 0, DW'(10*(i / IMG_W) + i % IMG_W));
         if (i == 2*IMG_W + 2) t22 = last_accept;
      end
      idle(4);
      checks++;
      if (obs_q.size() == 0 || obs_q[0].cyc !== t22 + 2) begin
         errors++;
         $display("[TB] FAIL latency_edge got=%0d exp=%0d", (obs_q.size() > 0) ? obs_q[0].cyc : -1, t22 + 2);
      end
      checks++;
      if (obs_q.size() == 0 || obs_q[0].data[8*DW +: DW] !== DW'(22)) begin
         errors++;
         $display("[TB] FAIL latency_k8 got=%0d exp=22", (obs_q.size() > 0) ? int'(obs_q[0].data[8*DW +: DW]) : -1);
      end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL latency_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_gaps();
      start_test();
      send_frame(0, 1'b1, 1'b1);
      idle(4);
      checks++;
      if (obs_q.size() !== exp_q.size() || exp_q.size() !== 6) begin
         errors++;
         $display("[TB] FAIL gaps_count got=%0d exp=6", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].sof !== exp_q[i].sof || obs_q[i].cyc !== exp_q[i].cyc) begin
            errors++;
            $display("[TB] FAIL gaps_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i, obs_q[i].data, obs_q[i].sof, obs_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].cyc);
         end
      end
   endtask

   task automatic test_second_frame();
      start_test();
      send_frame(100, 1'b1, 1'b0);
      idle(4);
      checks++;
      if (obs_q.size() == 0 || obs_q[0].data[0 +: DW] !== DW'(100) || obs_q[0].data[8*DW +: DW] !== DW'(122) || obs_q[0].sof !== 1'b1) begin
         errors++;
         $display("[TB] FAIL second_frame_first got=%h exp k0=100 k8=122 sof=1", (obs_q.size() > 0) ? obs_q[0].data : '0);
      end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL second_frame_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].sof !== exp_q[i].sof || obs_q[i].cyc !== exp_q[i].cyc) begin
            errors++;
            $display("[TB] FAIL second_frame_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i, obs_q[i].data, obs_q[i].sof, obs_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].cyc);
         end
      end
   endtask

   task automatic test_reset_mid();
      win_t keep[$];
      int   rr;
      start_test();
      for (int i = 0; i <= 2*IMG_W + 3; i++)
         applyStimulus(1'b1, i == 0, DW'(10*(i / IMG_W) + i % IMG_W));
      @(negedge i_clk);
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_rstn  = 1'b0;
      rr = cyc + 1;
      // Windows due on or after the reset edge are lost with the pipeline.
      foreach (exp_q[i]) if (exp_q[i].cyc < rr) keep.push_back(exp_q[i]);
      exp_q = keep;
      mx = 0;
      my = 0;
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0 || o_sof !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_outputs got valid=%b sof=%b exp 0/0", o_valid, o_sof);
      end
      i_rstn = 1'b1;
      send_frame(0, 1'b1, 1'b0);
      idle(4);
      checks++;
      if (obs_q.size() !== exp_q.size() || exp_q.size() !== 6) begin
         errors++;
         $display("[TB] FAIL reset_mid_count got=%0d exp=6", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].sof !== exp_q[i].sof || obs_q[i].cyc !== exp_q[i].cyc) begin
            errors++;
            $display("[TB] FAIL reset_mid_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i, obs_q[i].data, obs_q[i].sof, obs_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].cyc);
         end
      end
   endtask

   task automatic test_back_to_back();
      start_test();
      send_frame(0, 1'b1, 1'b0);
      send_frame(50, 1'b0, 1'b0);
      idle(4);
      checks++;
      if (obs_q.size() !== 12) begin
         errors++;
         $display("[TB] FAIL back_to_back_count got=%0d exp=12", obs_q.size());
      end
      checks++;
      if (obs_q.size() < 7 || obs_q[6].sof !== 1'b1 || obs_q[6].data[8*DW +: DW] !== DW'(72)) begin
         errors++;
         $display("[TB] FAIL back_to_back_second_sof got=%b exp=1 with k8=72", (obs_q.size() > 6) ? obs_q[6].sof : 1'b0);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].sof !== exp_q[i].sof || obs_q[i].cyc !== exp_q[i].cyc) begin
            errors++;
            $display("[TB] FAIL back_to_back_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i, obs_q[i].data, obs_q[i].sof, obs_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].cyc);
         end
      end
   endtask

   task automatic test_random_pixels();
      start_test();
      for (int i = 0; i < 3*IMG_W*IMG_H; i++) begin
         idle($urandom_range(0, 2));
         applyStimulus(1'b1, i == 0 || i == 27, DW'($urandom));
      end
      idle(4);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].sof !== exp_q[i].sof || obs_q[i].cyc !== exp_q[i].cyc) begin
            errors++;
            $display("[TB] FAIL random_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i, obs_q[i].data, obs_q[i].sof, obs_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].cyc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_latency();
      test_gaps();
      test_second_frame();
      test_reset_mid();
      test_back_to_back();
      test_random_pixels();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
